frame_pass_scheduler: RTL

Sequences the pixel BRAM write port. Accepted work is either a full-frame clear pass or one triangle scan pass. For a triangle pass it drives the raster coordinates into the 2D fill unit and turns the fill unit's delayed `is_within` into BRAM writes; for a clear pass it writes `CLEAR_COLOR` to every address. It replaces the free-running hcount/vcount scan and the switch-forced clear, giving the rasterization controller a valid/ready handshake and a `done` pulse per pass.

---
 rtl/frame_pass_scheduler_pkg.sv | 20 ++
 rtl/frame_pass_scheduler_if.sv | 44 ++++
 rtl/frame_pass_scheduler_pipe.sv | 30 +++
 rtl/frame_pass_scheduler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/frame_pass_scheduler_pkg.sv
// Shared types and defaults for the pixel-BRAM pass scheduler.
package frame_pass_scheduler_pkg;

    localparam int unsigned DefFrameWidth  = 512;
    localparam int unsigned DefFrameHeight = 384;
    localparam int unsigned PbramAddrBits  = 18;
    localparam int unsigned ColorWidthPad  = 16;
    localparam int unsigned DefCoordBits   = 16;
    localparam int unsigned DefTriWidth    = 96;
    localparam int unsigned DefFillLatency = 3;

    // Pass state: idle, full-frame clear, triangle scan, fill-pipeline drain.
    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StScan,
        StDrain
    } pass_state_e;

endpackage

// File: rtl/frame_pass_scheduler_if.sv
// Job handshake, fill-unit and BRAM port-A signals of the pass scheduler.
interface frame_pass_scheduler_if #(
    parameter int unsigned TRI_WIDTH   = frame_pass_scheduler_pkg::DefTriWidth,
    parameter int unsigned COLOR_WIDTH = frame_pass_scheduler_pkg::ColorWidthPad,
    parameter int unsigned COORD_BITS  = frame_pass_scheduler_pkg::DefCoordBits,
    parameter int unsigned ADDR_BITS   = frame_pass_scheduler_pkg::PbramAddrBits
) ();

    // Job side
    logic                   clear_req;
    logic                   tri_valid;
    logic                   tri_ready;
    logic [TRI_WIDTH-1:0]   tri_in;
    logic [COLOR_WIDTH-1:0] tri_color;
    logic                   busy;
    logic                   pass_done;

    // Fill-unit side
    logic [TRI_WIDTH-1:0]   fill_tri;
    logic                   fill_tri_load;
    logic [COORD_BITS-1:0]  hcount;
    logic [COORD_BITS-1:0]  vcount;
    logic                   fill_is_within;

    // BRAM port A
    logic                   pixel_we;
    logic [ADDR_BITS-1:0]   pixel_addr;
    logic [COLOR_WIDTH-1:0] pixel_data;

    // Environment: rasterization controller, fill unit and BRAM.
    modport master (
        output clear_req, tri_valid, tri_in, tri_color, fill_is_within,
        input  tri_ready, busy, pass_done, fill_tri, fill_tri_load, hcount, vcount,
        input  pixel_we, pixel_addr, pixel_data
    );

    // Scheduler.
    modport slave (
        input  clear_req, tri_valid, tri_in, tri_color, fill_is_within,
        output tri_ready, busy, pass_done, fill_tri, fill_tri_load, hcount, vcount,
        output pixel_we, pixel_addr, pixel_data
    );

endinterface

// File: rtl/frame_pass_scheduler_pipe.sv
// Fixed-length register delay line; every stage clears on reset.
module frame_pass_scheduler_pipe #(
    parameter int unsigned LENGTH = 3,
    parameter int unsigned WIDTH  = 33
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage_q [LENGTH];

    // Shift one stage per cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < LENGTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int unsigned i = 1; i < LENGTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[LENGTH-1];

endmodule

// File: rtl/frame_pass_scheduler.sv
// Sequences the pixel BRAM write port through clear passes and triangle scan passes.
module frame_pass_scheduler
    import frame_pass_scheduler_pkg::*;
#(
    parameter int unsigned FRAME_WIDTH  = DefFrameWidth,
    parameter int unsigned FRAME_HEIGHT = DefFrameHeight,
    parameter int unsigned ADDR_BITS    = PbramAddrBits,
    parameter int unsigned COORD_BITS   = DefCoordBits,
    parameter int unsigned COLOR_WIDTH  = ColorWidthPad,
    parameter int unsigned TRI_WIDTH    = DefTriWidth,
    parameter int unsigned FILL_LATENCY = DefFillLatency,
    parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0
) (
    input logic                   clk,
    input logic                   rst_n,
    frame_pass_scheduler_if.slave bus
);

    localparam int unsigned HBits    = $clog2(FRAME_WIDTH);
    localparam int unsigned DlyWidth = 2 * COORD_BITS + 1;
    localparam int unsigned CntBits  = (FILL_LATENCY > 1) ? $clog2(FILL_LATENCY) : 1;

    localparam logic [ADDR_BITS-1:0]  LastAddr  = ADDR_BITS'(FRAME_WIDTH * FRAME_HEIGHT - 1);
    localparam logic [COORD_BITS-1:0] LastH     = COORD_BITS'(FRAME_WIDTH - 1);
    localparam logic [COORD_BITS-1:0] LastV     = COORD_BITS'(FRAME_HEIGHT - 1);
    localparam logic [CntBits-1:0]    LastDrain = CntBits'(FILL_LATENCY - 1);

    pass_state_e            state_q, state_d;
    logic [COORD_BITS-1:0]  h_q, h_d;
    logic [COORD_BITS-1:0]  v_q, v_d;
    logic [ADDR_BITS-1:0]   clr_addr_q, clr_addr_d;
    logic [CntBits-1:0]     drain_q, drain_d;
    logic [TRI_WIDTH-1:0]   fill_tri_q, fill_tri_d;
    logic [COLOR_WIDTH-1:0] color_q, color_d;
    logic                   load_q, load_d;
    logic [ADDR_BITS-1:0]   last_addr_q;
    logic [COLOR_WIDTH-1:0] last_data_q;

    logic                   tri_ready;
    logic [DlyWidth-1:0]    dly_in, dly_out;
    logic                   dly_valid;
    logic [COORD_BITS-1:0]  dly_h, dly_v;
    logic [ADDR_BITS-1:0]   scan_addr;
    logic                   pix_we;
    logic [ADDR_BITS-1:0]   pix_addr;
    logic [COLOR_WIDTH-1:0] pix_data;
    logic                   done;

    // Gated by rst_n so no job can be offered an accept while reset is held.
    assign tri_ready = rst_n && (state_q == StIdle) && !bus.clear_req;

    // Next-state logic: pass sequencing, scan/clear counters and job capture.
    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        v_d        = v_q;
        clr_addr_d = clr_addr_q;
        drain_d    = drain_q;
        fill_tri_d = fill_tri_q;
        color_d    = color_q;
        load_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.clear_req) begin
                    state_d    = StClear;
                    clr_addr_d = '0;
                end else if (bus.tri_valid && tri_ready) begin
                    state_d    = StScan;
                    h_d        = '0;
                    v_d        = '0;
                    fill_tri_d = bus.tri_in;
                    color_d    = bus.tri_color;
                    load_d     = 1'b1;
                end
            end
            StClear: begin
                if (clr_addr_q == LastAddr) begin
                    state_d    = StIdle;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            StScan: begin
                if (h_q == LastH) begin
                    h_d = '0;
                    if (v_q == LastV) begin
                        v_d     = '0;
                        drain_d = '0;
                        state_d = StDrain;
                    end else begin
                        v_d = v_q + 1'b1;
                    end
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == LastDrain) begin
                    drain_d = '0;
                    state_d = StIdle;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any pass without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            h_q         <= '0;
            v_q         <= '0;
            clr_addr_q  <= '0;
            drain_q     <= '0;
            fill_tri_q  <= '0;
            color_q     <= '0;
            load_q      <= 1'b0;
            last_addr_q <= '0;
            last_data_q <= '0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            v_q         <= v_d;
            clr_addr_q  <= clr_addr_d;
            drain_q     <= drain_d;
            fill_tri_q  <= fill_tri_d;
            color_q     <= color_d;
            load_q      <= load_d;
            last_addr_q <= pix_addr;
            last_data_q <= pix_data;
        end
    end

    // Coordinates travel alongside the fill unit so the result meets its own address.
    assign dly_in = {(state_q == StScan), h_q, v_q};

    frame_pass_scheduler_pipe #(
        .LENGTH (FILL_LATENCY),
        .WIDTH  (DlyWidth)
    ) u_dly (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .data_i (dly_in),
        .data_o (dly_out)
    );

    assign {dly_valid, dly_h, dly_v} = dly_out;

    // FRAME_WIDTH is a power of two, so row-major addressing is a shift-or.
    assign scan_addr = (ADDR_BITS'(dly_v) << HBits) | ADDR_BITS'(dly_h);

    // Write-port mux; address and data hold their last value when nothing is written.
    always_comb begin
        pix_we   = 1'b0;
        pix_addr = last_addr_q;
        pix_data = last_data_q;
        done     = 1'b0;
        if (state_q == StClear) begin
            pix_we   = 1'b1;
            pix_addr = clr_addr_q;
            pix_data = CLEAR_COLOR;
            done     = (clr_addr_q == LastAddr);
        end else if (dly_valid) begin
            pix_we   = bus.fill_is_within;
            pix_addr = scan_addr;
            pix_data = color_q;
        end
        if ((state_q == StDrain) && (drain_q == LastDrain)) begin
            done = 1'b1;
        end
    end

    assign bus.tri_ready     = tri_ready;
    assign bus.busy          = (state_q != StIdle);
    assign bus.pass_done     = done;
    assign bus.fill_tri      = fill_tri_q;
    assign bus.fill_tri_load = load_q;
    assign bus.hcount        = h_q;
    assign bus.vcount        = v_q;
    assign bus.pixel_we      = pix_we;
    assign bus.pixel_addr    = pix_addr;
    assign bus.pixel_data    = pix_data;

endmodule
